// File: rtl/ps2_frame_rx_pkg.sv
// rtl/ps2_frame_rx_pkg.sv - shared PS/2 receive types and constants
package ps2_frame_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam int          PS2_FRAME_BITS   = 11;
    localparam logic [7:0]  PS2_BREAK_PREFIX = 8'hF0;

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - two-flop synchroniser plus debounce for one PS/2 pin
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic CLK_hPROC,
    input  logic nRESET,
    input  logic pin,
    output logic line
);

    localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

    logic       sync1;
    logic       sync2;
    logic [3:0] cnt;

    // Line flips only once FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge CLK_hPROC) begin
        if (!nRESET) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            line  <= 1'b1;
            cnt   <= 4'd0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (sync2 != line) begin
                if (cnt == CNT_LAST) begin
                    line <= sync2;
                    cnt  <= 4'd0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end else begin
                cnt <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 device-to-host frame receiver with parity, stop and timeout checks
module ps2_frame_rx
    import ps2_frame_rx_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic       CLK_hPROC,
    input  logic       nRESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] DATA,
    output logic       DONE,
    output logic       ERROR
);

    // The counter reads j-1 in the j-th cycle after a fall, so the registered
    // ERROR lands exactly TIMEOUT_CYC cycles after the fall cycle.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 2);

    ps2_state_t  state;
    ps2_state_t  state_nxt;
    logic        clk_f;
    logic        data_f;
    logic        clk_f_q;
    logic        fall;
    logic        timeout;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        parity_bit;
    logic [15:0] to_cnt;
    logic        frame_ok;
    logic        done_nxt;
    logic        err_nxt;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .CLK_hPROC (CLK_hPROC),
        .nRESET    (nRESET),
        .pin       (PS2_CLK),
        .line      (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .CLK_hPROC (CLK_hPROC),
        .nRESET    (nRESET),
        .pin       (PS2_DATA),
        .line      (data_f)
    );

    assign fall    = clk_f_q & ~clk_f;
    assign timeout = !fall && (state != ST_IDLE) && (to_cnt == TO_LAST);

    always_ff @(posedge CLK_hPROC) begin
        if (!nRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (fall && !data_f) state_nxt = ST_DATA;
            ST_DATA:   if (fall && bit_cnt == 3'd7) state_nxt = ST_PARITY;
                       else if (timeout) state_nxt = ST_IDLE;
            ST_PARITY: if (fall) state_nxt = ST_STOP;
                       else if (timeout) state_nxt = ST_IDLE;
            ST_STOP:   if (fall || timeout) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_ok = data_f && (^{shift, parity_bit});
        done_nxt = (state == ST_STOP) && fall && frame_ok;
        err_nxt  = ((state == ST_STOP) && fall && !frame_ok) || timeout;
    end

    always_ff @(posedge CLK_hPROC) begin
        if (!nRESET) begin
            clk_f_q    <= 1'b1;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            parity_bit <= 1'b0;
            to_cnt     <= 16'd0;
            DATA       <= 8'h00;
            DONE       <= 1'b0;
            ERROR      <= 1'b0;
        end else begin
            clk_f_q <= clk_f;
            DONE    <= done_nxt;
            ERROR   <= err_nxt;
            if (done_nxt) DATA <= shift;

            if (fall || state == ST_IDLE) to_cnt <= 16'd0;
            else if (to_cnt != 16'hFFFF)  to_cnt <= to_cnt + 16'd1;

            if (fall) begin
                case (state)
                    ST_IDLE:   bit_cnt <= 3'd0;
                    ST_DATA: begin
                        shift   <= {data_f, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ST_PARITY: parity_bit <= data_f;
                    default:   ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb/tb_ps2_frame_rx.sv - randomized self-checking bench for ps2_frame_rx
`timescale 1ns/1ps
module tb_ps2_frame_rx;
    import ps2_frame_rx_pkg::*;

    localparam int FL = 4;
    localparam int TO = 2000;

    logic       CLK_hPROC = 1'b0;
    logic       nRESET    = 1'b0;
    logic       PS2_CLK   = 1'b1;
    logic       PS2_DATA  = 1'b1;
    logic [7:0] DATA;
    logic       DONE;
    logic       ERROR;

    typedef struct {
        int         cyc;
        bit         done;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] exp_data = 8'h00;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         last_fall = 0;
    bit         chk_en = 1'b0;
    bit         rst_seen = 1'b0;

    ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .CLK_hPROC (CLK_hPROC),
        .nRESET    (nRESET),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .DATA      (DATA),
        .DONE      (DONE),
        .ERROR     (ERROR)
    );

    always #5 CLK_hPROC = ~CLK_hPROC;

    always @(posedge CLK_hPROC) begin
        cyc++;
        rst_seen = !nRESET;
    end

    // Every cycle: pulses must match the expected event list, DATA the last good byte.
    always @(negedge CLK_hPROC) begin
        ev_t e;
        if (chk_en) begin
            if (rst_seen) begin
                exp_data = 8'h00;
                exp_q.delete();
            end
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event: cycle %0d expected %s data %02h, nothing seen",
                         exp_q[0].cyc, exp_q[0].done ? "DONE" : "ERROR", exp_q[0].data);
                void'(exp_q.pop_front());
            end
            checks++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                if (DONE !== e.done || ERROR !== !e.done) begin
                    errors++;
                    $display("FAIL pulse: cycle %0d got DONE=%b ERROR=%b, required DONE=%b ERROR=%b",
                             cyc, DONE, ERROR, e.done, !e.done);
                end
                if (e.done) exp_data = e.data;
            end else if (DONE !== 1'b0 || ERROR !== 1'b0) begin
                errors++;
                $display("FAIL unexpected_pulse: cycle %0d got DONE=%b ERROR=%b, required 0/0",
                         cyc, DONE, ERROR);
            end
            checks++;
            if (DATA !== exp_data) begin
                errors++;
                $display("FAIL data_hold: cycle %0d got DATA=%02h required %02h", cyc, DATA, exp_data);
            end
        end
    end

    task automatic wait_cyc(input int n);
        if (n > 0) begin
            repeat (n) @(posedge CLK_hPROC);
            #1;
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %02h required %02h", name, act, req);
        end
    endtask

    // One PS/2 bit: data set while the clock is high, clock low for hp cycles.
    task automatic send_bit(input bit b, input int hp, input bit glitch);
        PS2_DATA = b;
        if (glitch) begin
            wait_cyc(hp / 2 - 1);
            PS2_CLK = 1'b0;
            wait_cyc(2);
            PS2_CLK = 1'b1;
            wait_cyc(hp - hp / 2 - 1);
        end else begin
            wait_cyc(hp);
        end
        PS2_CLK   = 1'b0;
        last_fall = cyc;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int hp, input bit glitch);
        logic [PS2_FRAME_BITS-1:0] bits;
        bit   par;
        bit   ok;
        ev_t  e;
        par  = ~(^b) ^ bad_par;
        bits = {~bad_stop, par, b, 1'b0};
        ok   = bits[10] && ((^b) ^ par);
        for (int i = 0; i < PS2_FRAME_BITS; i++) begin
            send_bit(bits[i], hp, glitch && i == 4);
            if (i == PS2_FRAME_BITS - 1) begin
                e.cyc  = last_fall + 2 + FL + 1;
                e.done = ok;
                e.data = b;
                exp_q.push_back(e);
            end
            wait_cyc(hp);
            PS2_CLK = 1'b1;
        end
        PS2_DATA = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] b, input int nfalls, input int hp);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int i = 0; i < nfalls; i++) begin
            send_bit(bits[i], hp, 1'b0);
            wait_cyc(hp);
            PS2_CLK = 1'b1;
        end
        PS2_DATA = 1'b1;
    endtask

    initial begin
        ev_t e;
        int  guard;
        logic [7:0] rb;

        wait_cyc(5);
        check_val("reset_data", DATA, 8'h00);
        check_val("reset_done", {7'd0, DONE}, 8'h00);
        check_val("reset_error", {7'd0, ERROR}, 8'h00);
        nRESET = 1'b1;
        wait_cyc(1);
        chk_en = 1'b1;
        wait_cyc(10);

        send_frame(8'h1C, 1'b0, 1'b0, 40, 1'b0);
        wait_cyc(30);
        check_val("frame_1c", DATA, 8'h1C);

        send_frame(PS2_BREAK_PREFIX, 1'b0, 1'b0, 25, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 25, 1'b0);
        wait_cyc(30);
        check_val("break_then_1c", DATA, 8'h1C);

        send_frame(8'h76, 1'b1, 1'b0, 30, 1'b0);
        wait_cyc(30);
        check_val("bad_parity_hold", DATA, 8'h1C);

        send_frame(8'h5A, 1'b0, 1'b1, 30, 1'b0);
        wait_cyc(30);
        check_val("bad_stop_hold", DATA, 8'h1C);
        send_frame(8'h5A, 1'b0, 1'b0, 30, 1'b0);
        wait_cyc(30);
        check_val("frame_5a", DATA, 8'h5A);

        send_partial(8'h29, 5, 30);
        e.cyc  = last_fall + 2 + FL + TO;
        e.done = 1'b0;
        e.data = 8'h00;
        exp_q.push_back(e);
        wait_cyc(TO + 50);
        check_val("timeout_hold", DATA, 8'h5A);
        send_frame(8'h29, 1'b0, 1'b0, 30, 1'b0);
        wait_cyc(30);
        check_val("frame_29", DATA, 8'h29);

        PS2_CLK = 1'b0;
        wait_cyc(2);
        PS2_CLK = 1'b1;
        wait_cyc(20);
        send_frame(8'h33, 1'b0, 1'b0, 40, 1'b1);
        wait_cyc(30);
        check_val("glitch_33", DATA, 8'h33);

        send_bit(1'b1, 30, 1'b0);
        wait_cyc(30);
        PS2_CLK = 1'b1;
        wait_cyc(30);
        send_frame(8'h45, 1'b0, 1'b0, 30, 1'b0);
        wait_cyc(30);
        check_val("spurious_then_45", DATA, 8'h45);

        send_partial(8'h6B, 5, 30);
        nRESET = 1'b0;
        wait_cyc(3);
        nRESET = 1'b1;
        wait_cyc(2);
        check_val("midframe_reset", DATA, 8'h00);
        wait_cyc(30);
        send_frame(8'h12, 1'b0, 1'b0, 30, 1'b0);
        wait_cyc(30);
        check_val("after_reset_12", DATA, 8'h12);

        for (int k = 0; k < 20; k++) begin
            rb = 8'($urandom);
            send_frame(rb, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                       $urandom_range(20, 50), $urandom_range(0, 1) == 1);
            wait_cyc($urandom_range(0, 30));
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            wait_cyc(1);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected events outstanding, required 0", exp_q.size());
        end
        wait_cyc(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_frame_rx.md
# ps2_frame_rx

PS/2 device-to-host frame receiver for the BBC micro keyboard path. It synchronises and deglitches the raw PS2_CLK/PS2_DATA pins, deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop) and presents each valid scan-code byte as DATA with a one-cycle DONE strobe. It sits directly upstream of the keyboard matrix block, which consumes DATA/DONE, including 0xF0 break prefixes, unmodified.

## Interface
- FILTER_LEN, 4: consecutive equal synchronised samples needed before a filtered line changes (1..15).
- TIMEOUT_CYC, 2000: idle cycles without a filtered PS2_CLK falling edge, mid-frame, before the frame is abandoned (must be greater than 2 PS/2 bit periods; 16-bit counter).
- CLK_hPROC  input  1  system clock; all state on rising edge.
- nRESET  input  1  reset, synchronous, active-low; clock CLK_hPROC.
- PS2_CLK  input  1  raw PS/2 clock pin, asynchronous, open-collector, idle high.
- PS2_DATA  input  1  raw PS/2 data pin, asynchronous, idle high.
- DATA  output  8  last correctly received byte; held until the next valid frame.
- DONE  output  1  one-cycle pulse: DATA has just been updated with a valid byte.
- ERROR  output  1  one-cycle pulse: frame discarded (parity, stop-bit or timeout).

## Operation
- Each pin: 2-flop synchroniser, then filter; filtered output (reset value 1) flips only after FILTER_LEN consecutive synchronised samples differ from it. Both pins use identical pipelines so they stay aligned.
- fall = filtered clock was 1 last cycle and is 0 now. All bit sampling uses filtered data in the fall cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0, clear the bit counter and go to DATA. On fall with data=1, stay in IDLE with no ERROR; this is a spurious start.
  - DATA: on fall, shift the data bit in at bit 7 of the shift register, shifting right (LSB-first). After the 8th bit, go to PARITY.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, the frame is valid when stop=1 and XOR(8 data bits, parity)=1. Valid: load DATA from the shift register and pulse DONE. Invalid: pulse ERROR and leave DATA unchanged. Either way, go to IDLE.
- Timeout counter: cleared on every fall and in IDLE; increments otherwise and saturates. Reaching TIMEOUT_CYC in DATA, PARITY or STOP returns the FSM to IDLE and pulses ERROR once.
- No host-to-device transmission; the pins are input only.
- Reset: FSM to IDLE; DATA=0x00, DONE=0, ERROR=0; filters to 1; counters to 0. A frame in progress is discarded silently with no ERROR.

## Timing
- Pin to filtered-line latency: 2 sync cycles plus FILTER_LEN cycles.
- DONE/ERROR are registered and go high in the cycle after the stop-bit fall cycle, for exactly 1 cycle. DATA changes in that same cycle and is stable from then on.
- DONE and ERROR are never high in the same cycle. A timeout coinciding with a fall is not an error: the fall wins and the counter clears.
- Back-to-back frames: an IDLE fall on the cycle after STOP is accepted.
- The filter rejects pulses shorter than FILTER_LEN cycles. The filtered PS/2 half-period must exceed FILTER_LEN+2 cycles.

## Structure
- Shared package: FSM state enum (IDLE, DATA, PARITY, STOP), frame-length constant 11, and the break-prefix constant 0xF0 (also used by the keyboard block).
- One sub-module, `ps2_line_filter` (synchroniser plus debounce, parameter FILTER_LEN), instantiated twice, once per pin. FSM, shift register, parity check and timeout live in the top.

## Test plan
- Valid frame 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1), half-period 40 cycles -> one DONE pulse with DATA=0x1C, ERROR stays 0.
- Sequence 0xF0 then 0x1C, back-to-back with minimum gap -> two DONE pulses, DATA=0xF0 then 0x1C.
- Frame 0x76 sent with parity inverted -> one ERROR pulse, no DONE, DATA keeps previous value.
- Frame 0x5A with stop bit 0 -> ERROR pulse. Then a valid 0x5A -> DONE with DATA=0x5A.
- Only 5 clock edges, then bus idle -> ERROR exactly TIMEOUT_CYC cycles after the last fall. A following valid 0x29 gives DONE with DATA=0x29.
- 2-cycle glitches on PS2_CLK in IDLE and mid-bit -> no extra bits, correct byte. nRESET low mid-frame -> DATA=0x00, no pulses; the next frame is received correctly.
